crc_host_seq: RTL and testbench

Host-side command sequencer for the `granth_crc_decelerator` nibble/command port; the other end of that interface. It takes a framed byte stream over a valid/ready handshake and splits each byte into two FEED nibble commands, inserting the pacing gaps the decelerator needs. At the end of a frame it issues four READ commands, assembles the 32-bit CRC, and presents it with a one-cycle valid pulse. It sits between a byte source (UART or test host) and the decelerator's `io_in[7:2]` / `io_out[7:0]` pins.

---
 rtl/crc_host_seq.sv | 171 +++++++++++++++++
 tb/tb_crc_host_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_host_seq.sv
// Host sequencer for the CRC decelerator: bytes become paced FEED nibbles, frame end triggers 4 READs and a CRC pulse.
// Latency: 2*GAP+3 cycles per byte (+1 for CLEAR on a frame's first byte), 4*(1+READ_LAT)+1 cycles of readout.
// Backpressure: in_ready is high only in IDLE. Optional CRC_HOST_CHECK_EN adds the crc_expect/crc_match compare.
module crc_host_seq #(
  parameter int GAP      = 4,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [1:0]  dev_cmd,
  output logic [3:0]  dev_data,
  input  logic [7:0]  dev_in,
  output logic [31:0] crc_out,
  output logic        crc_valid,
  output logic        busy
`ifdef CRC_HOST_CHECK_EN
  ,
  input  logic [31:0] crc_expect,
  output logic        crc_match
`endif
);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b01;
  localparam logic [1:0] CMD_FEED  = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam logic [3:0] GAP_N     = 4'(GAP - 1);
  localparam logic [3:0] LAT_N     = 4'(READ_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FEED_HI, S_GAP_HI, S_FEED_LO, S_GAP_LO, S_READ, S_CAP, S_DONE
  } state_t;

  state_t     state;
  logic [7:0] byte_q;
  logic       last_q;
  logic       frame_open;
  logic [3:0] cnt;
  logic [1:0] k;

`ifdef CRC_HOST_CHECK_EN
  // Full CRC as it will read once the final byte lands in crc_out.
  logic [31:0] crc_final;
  always_comb crc_final = {dev_in, crc_out[23:0]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      byte_q     <= 8'd0;
      last_q     <= 1'b0;
      frame_open <= 1'b0;
      cnt        <= 4'd0;
      k          <= 2'd0;
      in_ready   <= 1'b0;
      dev_cmd    <= CMD_NOP;
      dev_data   <= 4'd0;
      crc_out    <= 32'd0;
      crc_valid  <= 1'b0;
      busy       <= 1'b0;
`ifdef CRC_HOST_CHECK_EN
      crc_match  <= 1'b0;
`endif
    end else begin
      crc_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            byte_q   <= in_data;
            last_q   <= in_last;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (!frame_open) begin
              state      <= S_CLEAR;
              dev_cmd    <= CMD_CLEAR;
              dev_data   <= 4'd0;
              frame_open <= 1'b1;
            end else begin
              state    <= S_FEED_HI;
              dev_cmd  <= CMD_FEED;
              dev_data <= in_data[7:4];
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_CLEAR: begin
          state    <= S_FEED_HI;
          dev_cmd  <= CMD_FEED;
          dev_data <= byte_q[7:4];
        end
        S_FEED_HI: begin
          state    <= S_GAP_HI;
          dev_cmd  <= CMD_NOP;
          dev_data <= 4'd0;
          cnt      <= GAP_N;
        end
        S_GAP_HI: begin
          if (cnt == 4'd0) begin
            state    <= S_FEED_LO;
            dev_cmd  <= CMD_FEED;
            dev_data <= byte_q[3:0];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_FEED_LO: begin
          state    <= S_GAP_LO;
          dev_cmd  <= CMD_NOP;
          dev_data <= 4'd0;
          cnt      <= GAP_N;
        end
        S_GAP_LO: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (last_q) begin
            state    <= S_READ;
            dev_cmd  <= CMD_READ;
            dev_data <= 4'd0;
            k        <= 2'd0;
          end else begin
            // Frame stays open, so busy remains asserted while waiting for the next byte.
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_READ: begin
          state    <= S_CAP;
          dev_cmd  <= CMD_NOP;
          dev_data <= 4'd0;
          cnt      <= LAT_N;
        end
        S_CAP: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            crc_out[8*k +: 8] <= dev_in;
            if (k == 2'd3) begin
              state      <= S_DONE;
              crc_valid  <= 1'b1;
              frame_open <= 1'b0;
`ifdef CRC_HOST_CHECK_EN
              crc_match  <= (crc_final == crc_expect);
`endif
            end else begin
              k        <= k + 2'd1;
              state    <= S_READ;
              dev_cmd  <= CMD_READ;
              dev_data <= {2'b00, k + 2'd1};
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          dev_cmd  <= CMD_NOP;
          dev_data <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_host_seq.sv
// Directed bench: default-parameter DUT (a) and GAP=1/READ_LAT=3 DUT (b), each with a READ_LAT-delayed device model.
module tb_crc_host_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        sel;
  logic [31:0] crc_expect;

  logic        in_valid_a, in_ready_a, crc_valid_a, busy_a;
  logic [1:0]  dev_cmd_a;
  logic [3:0]  dev_data_a;
  logic [7:0]  dev_in_a;
  logic [31:0] crc_out_a;
  logic        in_valid_b, in_ready_b, crc_valid_b, busy_b;
  logic [1:0]  dev_cmd_b;
  logic [3:0]  dev_data_b;
  logic [7:0]  dev_in_b;
  logic [31:0] crc_out_b;
  logic        crc_match_a, crc_match_b;

  logic        cur_in_ready, cur_crc_valid, cur_busy, cur_match;
  logic [1:0]  cur_cmd;
  logic [3:0]  cur_data;
  logic [31:0] cur_crc;

  int total = 0;
  int bad   = 0;
  logic [5:0] exq[$];

  always #5 clk = ~clk;

  assign in_valid_a = in_valid & ~sel;
  assign in_valid_b = in_valid & sel;

  crc_host_seq u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a), .in_last(in_last),
    .in_ready(in_ready_a), .dev_cmd(dev_cmd_a), .dev_data(dev_data_a), .dev_in(dev_in_a),
    .crc_out(crc_out_a), .crc_valid(crc_valid_a), .busy(busy_a)
`ifdef CRC_HOST_CHECK_EN
    , .crc_expect(crc_expect), .crc_match(crc_match_a)
`endif
  );

  crc_host_seq #(.GAP(1), .READ_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b), .in_last(in_last),
    .in_ready(in_ready_b), .dev_cmd(dev_cmd_b), .dev_data(dev_data_b), .dev_in(dev_in_b),
    .crc_out(crc_out_b), .crc_valid(crc_valid_b), .busy(busy_b)
`ifdef CRC_HOST_CHECK_EN
    , .crc_expect(crc_expect), .crc_match(crc_match_b)
`endif
  );

`ifndef CRC_HOST_CHECK_EN
  assign crc_match_a = 1'b0;
  assign crc_match_b = 1'b0;
`endif

  // Device models: return 0x10+k exactly READ_LAT cycles after READ k, 0xEE otherwise.
  logic       va;
  logic [1:0] ka;
  logic [2:0] vb;
  logic [1:0] kb [3];
  always @(posedge clk) begin
    va    <= (dev_cmd_a == 2'b11);
    ka    <= dev_data_a[1:0];
    vb    <= {vb[1:0], dev_cmd_b == 2'b11};
    kb[0] <= dev_data_b[1:0];
    kb[1] <= kb[0];
    kb[2] <= kb[1];
  end
  assign dev_in_a = va    ? (8'h10 + {6'd0, ka})    : 8'hEE;
  assign dev_in_b = vb[2] ? (8'h10 + {6'd0, kb[2]}) : 8'hEE;

  assign cur_in_ready  = sel ? in_ready_b  : in_ready_a;
  assign cur_crc_valid = sel ? crc_valid_b : crc_valid_a;
  assign cur_busy      = sel ? busy_b      : busy_a;
  assign cur_match     = sel ? crc_match_b : crc_match_a;
  assign cur_cmd       = sel ? dev_cmd_b   : dev_cmd_a;
  assign cur_data      = sel ? dev_data_b  : dev_data_a;
  assign cur_crc       = sel ? crc_out_b   : crc_out_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [1:0] c, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) exq.push_back({c, d});
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!cur_in_ready && n < 60) begin
      tick();
      n++;
    end
    check("rdy_timeout", {31'd0, cur_in_ready}, 32'd1);
  endtask

  // Sends one last-flagged byte and compares the per-cycle command trace against exq.
  task automatic run_trace(input string tag, input logic [7:0] b, input logic [31:0] exp_crc);
    int pulses = 0;
    int pos = -1;
    logic [31:0] crc_at = 32'd0;
    wait_rdy();
    in_valid = 1'b1; in_data = b; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < exq.size(); i++) begin
      check($sformatf("%s_cmd%0d", tag, i), {26'd0, cur_cmd, cur_data}, {26'd0, exq[i]});
      if (cur_crc_valid) begin pulses++; pos = i; crc_at = cur_crc; end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (cur_crc_valid) pulses++;
      tick();
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_pulse_pos"}, pos, exq.size() - 1);
    check({tag, "_crc"}, crc_at, exp_crc);
    exq.delete();
  endtask

  initial begin
    int t[3];
    int idx, cyc, feeds, clears, pulses, n;
    logic hs;
    logic [7:0] bytes3 [3];
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; sel = 1'b0;
    crc_expect = 32'h13121110;
    #2 rst = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd", {30'd0, dev_cmd_a}, 32'd0);
    check("rst_data", {28'd0, dev_data_a}, 32'd0);
    check("rst_rdy", {31'd0, in_ready_a}, 32'd0);
    check("rst_crc", crc_out_a, 32'd0);
    check("rst_vld", {31'd0, crc_valid_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    check("post_rst_rdy", {31'd0, in_ready_a}, 32'd1);
    check("post_rst_cmd", {30'd0, dev_cmd_a}, 32'd0);

    // Single byte 0xA5, defaults
    ex(2'b01, 4'h0, 1); ex(2'b10, 4'hA, 1); ex(2'b00, 4'h0, 4);
    ex(2'b10, 4'h5, 1); ex(2'b00, 4'h0, 4);
    for (int k = 0; k < 4; k++) begin ex(2'b11, 4'(k), 1); ex(2'b00, 4'h0, 1); end
    ex(2'b00, 4'h0, 1);
    run_trace("a5", 8'hA5, 32'h13121110);
`ifdef CRC_HOST_CHECK_EN
    check("match_hit", {31'd0, cur_match}, 32'd1);
`endif
    check("idle_busy", {31'd0, cur_busy}, 32'd0);

    // Three-byte frame with in_valid held high while busy
    crc_expect = 32'h13121111;
    bytes3[0] = 8'h31; bytes3[1] = 8'h32; bytes3[2] = 8'h33;
    idx = 0; cyc = 0; feeds = 0; clears = 0; pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (cur_cmd == 2'b10) feeds++;
      if (cur_cmd == 2'b01) clears++;
      if (cur_crc_valid) pulses++;
      in_valid = (idx < 3);
      in_data  = bytes3[idx < 3 ? idx : 2];
      in_last  = (idx == 2);
      hs = in_valid && cur_in_ready;
      tick();
      cyc++;
      if (hs) begin t[idx] = cyc; idx++; end
    end
    in_valid = 1'b0;
    check("f3_handshakes", idx, 3);
    check("f3_gap1", t[1] - t[0], 12);
    check("f3_gap2", t[2] - t[1], 11);
    check("f3_clears", clears, 1);
    check("f3_feeds", feeds, 6);
    check("f3_pulses", pulses, 1);
    check("f3_crc", crc_out_a, 32'h13121110);
`ifdef CRC_HOST_CHECK_EN
    check("match_miss", {31'd0, cur_match}, 32'd0);
`endif

    // GAP=1, READ_LAT=3 on DUT b
    sel = 1'b1;
    crc_expect = 32'h13121110;
    ex(2'b01, 4'h0, 1); ex(2'b10, 4'h5, 1); ex(2'b00, 4'h0, 1);
    ex(2'b10, 4'hA, 1); ex(2'b00, 4'h0, 1);
    for (int k = 0; k < 4; k++) begin ex(2'b11, 4'(k), 1); ex(2'b00, 4'h0, 3); end
    ex(2'b00, 4'h0, 1);
    run_trace("g1l3", 8'h5A, 32'h13121110);

    // Reset during READ k=2 on DUT a
    sel = 1'b0;
    wait_rdy();
    in_valid = 1'b1; in_data = 8'hC3; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!(cur_cmd == 2'b11 && cur_data == 4'd2) && n < 60) begin
      tick();
      n++;
    end
    check("mid_read2_seen", {28'd0, cur_data}, 32'd2);
    rst = 1'b0;
    #1;
    check("mid_cmd", {30'd0, cur_cmd}, 32'd0);
    check("mid_crc", cur_crc, 32'd0);
    check("mid_vld", {31'd0, cur_crc_valid}, 32'd0);
    check("mid_busy", {31'd0, cur_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cur_crc_valid || cur_cmd != 2'b00) pulses++;
    end
    check("mid_quiet", pulses, 0);
    ex(2'b01, 4'h0, 1); ex(2'b10, 4'hA, 1); ex(2'b00, 4'h0, 4);
    ex(2'b10, 4'h5, 1); ex(2'b00, 4'h0, 4);
    for (int k = 0; k < 4; k++) begin ex(2'b11, 4'(k), 1); ex(2'b00, 4'h0, 1); end
    ex(2'b00, 4'h0, 1);
    run_trace("after_rst", 8'hA5, 32'h13121110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
